// File: rtl/ps2_ascii_writer.sv
// PS/2 set-2 keyboard receiver and decoder that feeds the character display buffer.
// Each decoded code is presented on ascii one cycle before a fixed-length dataReady strobe.
module ps2_ascii_writer #(
    parameter int FILTER_LEN  = 8,
    parameter int STROBE_LEN  = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk_pix,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] ascii,
    output logic       dataReady,
    output logic       frame_err,
    output logic       overflow
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int SW = $clog2(STROBE_LEN + 1);

    typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} dec_t;
    typedef enum logic [1:0] {IDLE_OUT, SETUP, STROBE, GAP} seq_t;

    logic [1:0]    clk_s, dat_s;
    logic          filt_clk, fall;
    logic [FW-1:0] flt_cnt;
    logic [3:0]    bit_cnt;
    logic [TW-1:0] idle_cnt;
    logic [7:0]    sh, rx_byte;
    logic          start_ok, par, byte_vld;
    dec_t          dstate, dnext;
    logic          shift, shift_set, shift_clr, dec_vld;
    logic [7:0]    dec_ch;
    logic          pend_vld, take;
    logic [7:0]    pend_ch;
    seq_t          sstate, snext;
    logic [SW-1:0] scnt;

    function automatic logic [8:0] lut_std(input logic [7:0] c, input logic s);
        logic [7:0] lc, dg, sy;
        lc = 8'h00; dg = 8'h00; sy = 8'h00;
        case (c)
            8'h1C: lc = "a"; 8'h32: lc = "b"; 8'h21: lc = "c"; 8'h23: lc = "d";
            8'h24: lc = "e"; 8'h2B: lc = "f"; 8'h34: lc = "g"; 8'h33: lc = "h";
            8'h43: lc = "i"; 8'h3B: lc = "j"; 8'h42: lc = "k"; 8'h4B: lc = "l";
            8'h3A: lc = "m"; 8'h31: lc = "n"; 8'h44: lc = "o"; 8'h4D: lc = "p";
            8'h15: lc = "q"; 8'h2D: lc = "r"; 8'h1B: lc = "s"; 8'h2C: lc = "t";
            8'h3C: lc = "u"; 8'h2A: lc = "v"; 8'h1D: lc = "w"; 8'h22: lc = "x";
            8'h35: lc = "y"; 8'h1A: lc = "z";
            8'h16: begin dg = "1"; sy = "!"; end
            8'h1E: begin dg = "2"; sy = "@"; end
            8'h26: begin dg = "3"; sy = "#"; end
            8'h25: begin dg = "4"; sy = "$"; end
            8'h2E: begin dg = "5"; sy = "%"; end
            8'h36: begin dg = "6"; sy = "^"; end
            8'h3D: begin dg = "7"; sy = "&"; end
            8'h3E: begin dg = "8"; sy = "*"; end
            8'h46: begin dg = "9"; sy = "("; end
            8'h45: begin dg = "0"; sy = ")"; end
            default: ;
        endcase
        if (lc != 8'h00)      return {1'b1, s ? lc - 8'h20 : lc};
        else if (dg != 8'h00) return {1'b1, s ? sy : dg};
        case (c)
            8'h29:   return {1'b1, 8'h20};
            8'h5A:   return {1'b1, 8'h0D};
            8'h66:   return {1'b1, 8'h7F};
            8'h05:   return {1'b1, 8'h02};
            default: return 9'h000;
        endcase
    endfunction

    function automatic logic [8:0] lut_ext(input logic [7:0] c);
        case (c)
            8'h75:   return {1'b1, 8'h12};
            8'h72:   return {1'b1, 8'h13};
            8'h6B:   return {1'b1, 8'h11};
            8'h74:   return {1'b1, 8'h14};
            default: return 9'h000;
        endcase
    endfunction

    // fall fires on the edge where the debounced clock commits to 0
    assign fall = filt_clk && !clk_s[1] && (flt_cnt == FW'(FILTER_LEN - 1));

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            clk_s <= '0; dat_s <= '0; filt_clk <= 1'b0; flt_cnt <= '0;
        end else begin
            clk_s <= {clk_s[0], ps2_clk};
            dat_s <= {dat_s[0], ps2_data};
            if (clk_s[1] == filt_clk) flt_cnt <= '0;
            else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
                filt_clk <= clk_s[1];
                flt_cnt  <= '0;
            end else flt_cnt <= flt_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            bit_cnt <= '0; idle_cnt <= '0; sh <= '0; rx_byte <= '0;
            start_ok <= 1'b0; par <= 1'b0; byte_vld <= 1'b0; frame_err <= 1'b0;
        end else begin
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
            if (fall) begin
                idle_cnt <= '0;
                bit_cnt  <= (bit_cnt == 4'd10) ? 4'd0 : bit_cnt + 4'd1;
                if (bit_cnt == 4'd0) start_ok <= !dat_s[1];
                else if (bit_cnt <= 4'd8) sh <= {dat_s[1], sh[7:1]};
                else if (bit_cnt == 4'd9) par <= dat_s[1];
                else if (start_ok && dat_s[1] && (^{sh, par})) begin
                    rx_byte  <= sh;
                    byte_vld <= 1'b1;
                end else frame_err <= 1'b1;
            end else if (bit_cnt != 4'd0) begin
                if (idle_cnt == TW'(TIMEOUT_CYC - 1)) begin
                    bit_cnt  <= '0;
                    idle_cnt <= '0;
                end else idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            dstate <= IDLE;
            shift  <= 1'b0;
        end else begin
            dstate <= dnext;
            if (shift_set) shift <= 1'b1;
            else if (shift_clr) shift <= 1'b0;
        end
    end

    always_comb begin
        dnext = dstate;
        if (frame_err) dnext = IDLE;
        else if (byte_vld) begin
            case (dstate)
                IDLE:    if (rx_byte == 8'hE0) dnext = GOT_E0;
                         else if (rx_byte == 8'hF0) dnext = GOT_F0;
                GOT_E0:  dnext = (rx_byte == 8'hF0) ? GOT_E0F0 : IDLE;
                default: dnext = IDLE;
            endcase
        end
    end

    always_comb begin
        shift_set = 1'b0; shift_clr = 1'b0; dec_vld = 1'b0; dec_ch = 8'h00;
        if (byte_vld) begin
            case (dstate)
                IDLE:
                    if (rx_byte == 8'h12 || rx_byte == 8'h59) shift_set = 1'b1;
                    else if (rx_byte != 8'hE0 && rx_byte != 8'hF0)
                        {dec_vld, dec_ch} = lut_std(rx_byte, shift);
                GOT_E0:
                    if (rx_byte != 8'hF0) {dec_vld, dec_ch} = lut_ext(rx_byte);
                GOT_F0:
                    shift_clr = (rx_byte == 8'h12 || rx_byte == 8'h59);
                default: ;
            endcase
        end
    end

    assign take = (sstate == IDLE_OUT) && pend_vld;

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            sstate <= IDLE_OUT; scnt <= '0; ascii <= '0;
            pend_vld <= 1'b0; pend_ch <= '0; overflow <= 1'b0;
        end else begin
            sstate   <= snext;
            scnt     <= (snext != sstate) ? '0 : scnt + 1'b1;
            overflow <= 1'b0;
            if (take) ascii <= pend_ch;
            // a slot freed this cycle can accept the new character
            if (dec_vld) begin
                if (pend_vld && !take) overflow <= 1'b1;
                else begin
                    pend_ch  <= dec_ch;
                    pend_vld <= 1'b1;
                end
            end else if (take) pend_vld <= 1'b0;
        end
    end

    always_comb begin
        snext = sstate;
        case (sstate)
            IDLE_OUT: if (pend_vld) snext = SETUP;
            SETUP:    snext = STROBE;
            STROBE:   if (scnt == SW'(STROBE_LEN - 1)) snext = GAP;
            GAP:      if (scnt == SW'(STROBE_LEN - 1)) snext = IDLE_OUT;
            default:  snext = IDLE_OUT;
        endcase
    end

    always_comb begin
        dataReady = (sstate == STROBE);
    end
endmodule

// File: tb/tb_ps2_ascii_writer.sv
// Directed bench for ps2_ascii_writer: drives PS/2 frames and checks strobed codes.
module tb_ps2_ascii_writer;
    logic       clk_pix = 1'b0;
    logic       rst, ps2_clk, ps2_data;
    logic [7:0] ascii;
    logic       dataReady, frame_err, overflow;

    int checks = 0, errors = 0;
    int cyc = 0, chg_cyc = 0, rise_lag = 0, hi_len = 0, last_hi = 0;
    int err_cnt = 0, ovf_cnt = 0;
    logic [7:0] prev_ascii = 8'h00;
    logic       prev_dr = 1'b0;
    logic [7:0] q[$];

    ps2_ascii_writer dut (
        .clk_pix(clk_pix), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .ascii(ascii), .dataReady(dataReady), .frame_err(frame_err), .overflow(overflow)
    );

    always #5 clk_pix = ~clk_pix;

    initial forever begin
        @(negedge clk_pix);
        cyc++;
        if (ascii != prev_ascii) begin chg_cyc = cyc; prev_ascii = ascii; end
        if (dataReady && !prev_dr) begin q.push_back(ascii); rise_lag = cyc - chg_cyc; hi_len = 0; end
        if (dataReady) hi_len++;
        if (!dataReady && prev_dr) last_hi = hi_len;
        prev_dr = dataReady;
        if (frame_err) err_cnt++;
        if (overflow) ovf_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_pix);
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_cyc(10);
        ps2_clk = 1'b0;
        wait_cyc(20);
        ps2_clk = 1'b1;
        wait_cyc(10);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic bad_par = 1'b0);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(bad_par ? ^d : ~^d);
        send_bit(1'b1);
        wait_cyc(40);
    endtask

    initial begin
        logic [7:0] seq[$];
        int e0;
        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
        wait_cyc(3);
        @(negedge clk_pix);
        chk("rst_ascii", 32'(ascii), 32'h00);
        chk("rst_dr", 32'(dataReady), 32'h0);
        chk("rst_ferr", 32'(frame_err), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'h0);
        rst = 1'b0;
        wait_cyc(50);

        q.delete();
        send_byte(8'h1C);
        chk("a_cnt", 32'(q.size()), 32'd1);
        chk("a_char", 32'(q[0]), 32'h61);
        chk("a_hi_len", 32'(last_hi), 32'd4);
        chk("a_setup", 32'(rise_lag), 32'd1);
        chk("a_held", 32'(ascii), 32'h61);

        q.delete();
        seq = '{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12, 8'h1C};
        foreach (seq[i]) send_byte(seq[i]);
        chk("shift_cnt", 32'(q.size()), 32'd2);
        chk("shift_A", 32'(q[0]), 32'h41);
        chk("shift_a", 32'(q[1]), 32'h61);

        q.delete();
        seq = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hE0, 8'h6B};
        foreach (seq[i]) send_byte(seq[i]);
        chk("ext_cnt", 32'(q.size()), 32'd2);
        chk("ext_up", 32'(q[0]), 32'h12);
        chk("ext_left", 32'(q[1]), 32'h11);

        q.delete();
        seq = '{8'h59, 8'h45, 8'hF0, 8'h59, 8'h45};
        foreach (seq[i]) send_byte(seq[i]);
        chk("dig_cnt", 32'(q.size()), 32'd2);
        chk("dig_rparen", 32'(q[0]), 32'h29);
        chk("dig_zero", 32'(q[1]), 32'h30);

        q.delete();
        e0 = err_cnt;
        send_byte(8'h1C, 1'b1);
        chk("par_ferr", 32'(err_cnt - e0), 32'd1);
        chk("par_nostrobe", 32'(q.size()), 32'd0);
        send_byte(8'h29);
        chk("par_next_cnt", 32'(q.size()), 32'd1);
        chk("par_next_sp", 32'(q[0]), 32'h20);

        q.delete();
        e0 = err_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        wait_cyc(50001);
        send_byte(8'h5A);
        chk("tmo_cnt", 32'(q.size()), 32'd1);
        chk("tmo_enter", 32'(q[0]), 32'h0D);
        chk("tmo_noerr", 32'(err_cnt - e0), 32'd0);

        q.delete();
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        ps2_data = 1'b0;
        wait_cyc(10);
        ps2_clk = 1'b0;
        wait_cyc(5);
        rst = 1'b1;
        @(negedge clk_pix);
        chk("mrst_ascii", 32'(ascii), 32'h00);
        chk("mrst_dr", 32'(dataReady), 32'h0);
        @(posedge clk_pix);
        rst = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(60);
        send_byte(8'h66);
        send_byte(8'h05);
        chk("mrst_cnt", 32'(q.size()), 32'd2);
        chk("mrst_bs", 32'(q[0]), 32'h7F);
        chk("mrst_clr", 32'(q[1]), 32'h02);
        chk("no_ovf", 32'(ovf_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ps2_ascii_writer.md
Name: ps2_ascii_writer

Overview:
- Keyboard-side producer for the character display buffer: receives PS/2 scan-code set 2 frames and decodes them into the ASCII/control codes the buffer consumes.
- Delivers each code on ascii with an edge-safe dataReady strobe; the buffer captures on the dataReady rising edge.
- Sits between the board PS/2 pins and the display buffer, in the clk_pix domain.

Parameters:
- FILTER_LEN, 8: cycles ps2_clk must be stable before its filtered value changes.
- STROBE_LEN, 4: cycles dataReady stays high per character; minimum low gap is the same length.
- TIMEOUT_CYC, 50000: idle cycles mid-frame before the partial frame is discarded (2 ms at 25 MHz).

Ports:
- clk_pix  input  1  pixel clock, the only clock.
- rst  input  1  synchronous reset, active-high.
- ps2_clk  input  1  raw PS/2 clock, asynchronous.
- ps2_data  input  1  raw PS/2 data, asynchronous.
- ascii  output  8  decoded character/control code, held until the next character.
- dataReady  output  1  write strobe to the display buffer.
- frame_err  output  1  one-cycle pulse on a rejected frame.
- overflow  output  1  one-cycle pulse when a decoded character is dropped.

Behaviour:
- Interface: one clock, clk_pix; reset rst is synchronous and active-high. All outputs clear to 0 on reset; every internal register clears, including prefix flags, shift state, bit counter and pending slot. Reset mid-frame or mid-strobe aborts immediately, and dataReady goes low in the reset cycle.
- Input conditioning: ps2_clk and ps2_data each pass through a 2-FF synchronizer. ps2_clk is also debounced with a FILTER_LEN counter. A falling edge of the filtered clock samples the synchronized data.
- Frame format: 11 bits: start=0, 8 data bits LSB first, odd parity, stop=1. The byte is accepted on the stop-bit sample.
- Bad start, parity or stop: drop the byte, pulse frame_err, clear the E0/F0 prefix flags. Shift state is kept.
- Timeout: bit counter nonzero and no falling edge for TIMEOUT_CYC cycles -> counter returns to 0 silently, with no frame_err.
- Decoder FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0.
  - IDLE: E0 -> GOT_E0; F0 -> GOT_F0; 0x12 or 0x59 sets shift; any other byte is a make code -> lookup.
  - GOT_E0: F0 -> GOT_E0F0; else extended make -> lookup, -> IDLE.
  - GOT_F0: 0x12 or 0x59 clears shift; else ignored; -> IDLE.
  - GOT_E0F0: any byte ignored -> IDLE.
- Lookup table (unlisted codes emit nothing):
  - Letters a–z: standard US set-2 map, output 0x61–0x7A, or 0x41–0x5A with shift. Example: 0x1C -> 'a'.
  - Digits 0–9: output 0x30–0x39; with shift, US symbols ! @ # $ % ^ & * ( ).
  - 0x29 space -> 0x20; 0x5A -> 0x0D (enter); 0x66 -> 0x7F (backspace); 0x05 (F1) -> 0x02 (clear).
  - Extended: E0 75 -> 0x12 (up), E0 72 -> 0x13 (down), E0 6B -> 0x11 (left), E0 74 -> 0x14 (right).
  - Typematic repeats are make codes and emit again.
- Output sequencer states: IDLE_OUT, SETUP, STROBE, GAP.
  - IDLE_OUT with a pending character: load ascii -> SETUP (1 cycle, dataReady=0, so ascii is stable before the edge).
  - STROBE: dataReady=1 for STROBE_LEN cycles.
  - GAP: dataReady=0 for STROBE_LEN cycles -> IDLE_OUT.
- Latency: stop-bit sample -> ascii valid 2 cycles later; dataReady rises 1 cycle after ascii.
- Pending slot: one entry. A character decoded while the slot is full is dropped with an overflow pulse. A frame_err and a decode in the same cycle cannot occur.

Test Plan:
- Frame 0x1C -> ascii=0x61, dataReady high exactly 4 cycles; ascii changes one cycle before the rise and is held afterwards.
- Bytes 12, 1C, F0 1C, F0 12, 1C -> two strobes, ascii 0x41 then 0x61; break codes produce no strobe.
- Bytes E0 75, E0 F0 75, E0 6B -> strobes with 0x12 then 0x11 only.
- Frame 0x1C with even parity -> frame_err one pulse, no dataReady; next frame 0x29 -> ascii 0x20.
- 5 bits of a frame, idle 50001 cycles, then full frame 0x5A -> ascii 0x0D, frame_err never asserted.
- rst high during bit 4 of a frame -> ascii=0, dataReady=0 next cycle; then frames 0x66 and 0x05 -> ascii 0x7F then 0x02.
